// File: rtl/simon_pkg.sv
// simon_pkg: shared colour, playback-state and LFSR definitions for the Simon Says datapath
package simon_pkg;
  typedef enum logic [1:0] {RED, GREEN, BLUE, YELLOW} colour_t;
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} play_state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [3:0] onehot(input colour_t c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the colour source
module lfsr16 import simon_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);
  logic [15:0] q_d, q_q;
  // shift left and feed the tap parity into bit 0
  always_comb q_d = en ? {q_q[14:0], ^(q_q & LFSR_TAPS)} : q_q;
  // state register, restarts from the seed
  always_ff @(posedge clk or negedge reset)
    if (!reset) q_q <= SEED;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/sequence_engine.sv
// sequence_engine: stores the Simon colour sequence, plays it back with timed pulses and checks entries
module sequence_engine import simon_pkg::*; #(
  parameter int          MAX_ROUNDS = 32,
  parameter int          BASE_TICKS = 50_000_000,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       add_clr,
  input  logic [5:0] current_round,
  input  logic       speed_up,
  input  logic       play_start,
  output logic       pulse,
  output logic       play_done,
  output logic [3:0] led,
  input  logic       check,
  input  logic [3:0] player_input,
  output logic       result,
  output logic       result_valid
);
  localparam int AW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  colour_t     mem [MAX_ROUNDS];
  logic [1:0]  rnd;
  logic [13:0] lfsr_unused;
  play_state_t state_d, state_q;
  logic [5:0]  idx_d, idx_q, chk_idx_d, chk_idx_q;
  logic [31:0] cnt_d, cnt_q, base, len;
  logic [1:0]  level_d, level_q;
  logic [3:0]  led_d, led_q;
  logic        pulse_d, pulse_q, play_done_d, play_done_q;
  logic        result_d, result_q, result_valid_d, result_valid_q, match;

  lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .reset(reset), .en(1'b1), .q({lfsr_unused, rnd}));

  assign base = 32'(BASE_TICKS) >> level_q;
  assign len  = base == 32'd0 ? 32'd1 : base;

  // append a random colour; the array is intentionally left uncleared by reset
  always_ff @(posedge clk)
    if (add_clr && 32'(current_round) < MAX_ROUNDS) mem[current_round[AW-1:0]] <= colour_t'(rnd);

  // playback state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;

  // playback next state, play index and phase counter
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (play_start) begin
      state_d = current_round == 6'd0 ? S_DONE : S_ON;
      idx_d   = '0;
      cnt_d   = len - 32'd1;
    end else begin
      case (state_q)
        S_ON: begin
          state_d = cnt_q == 32'd0 ? S_OFF : S_ON;
          cnt_d   = cnt_q == 32'd0 ? len - 32'd1 : cnt_q - 32'd1;
        end
        S_OFF: begin
          idx_d   = cnt_q == 32'd0 ? idx_q + 6'd1 : idx_q;
          state_d = cnt_q != 32'd0 ? S_OFF : (idx_q + 6'd1 >= current_round) ? S_DONE : S_ON;
          cnt_d   = cnt_q == 32'd0 ? len - 32'd1 : cnt_q - 32'd1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // playback outputs derived from the upcoming state so they can be registered
  always_comb begin
    led_d       = state_d == S_ON ? onehot(mem[idx_d[AW-1:0]]) : 4'd0;
    pulse_d     = (state_d == S_ON || state_d == S_OFF) && cnt_d == 32'd0;
    play_done_d = state_d == S_DONE;
  end

  // entry checker and saturating speed level
  always_comb begin
    match          = player_input == onehot(mem[chk_idx_q[AW-1:0]]);
    result_valid_d = check;
    result_d       = check && match;
    chk_idx_d      = play_start ? 6'd0 : (check && match) ? chk_idx_q + 6'd1 : chk_idx_q;
    level_d        = speed_up && level_q != 2'd3 ? level_q + 2'd1 : level_q;
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx_q          <= '0;
      cnt_q          <= '0;
      chk_idx_q      <= '0;
      level_q        <= '0;
      led_q          <= '0;
      pulse_q        <= 1'b0;
      play_done_q    <= 1'b0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      chk_idx_q      <= chk_idx_d;
      level_q        <= level_d;
      led_q          <= led_d;
      pulse_q        <= pulse_d;
      play_done_q    <= play_done_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end

  assign led          = led_q;
  assign pulse        = pulse_q;
  assign play_done    = play_done_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
endmodule
